// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states and buffered
// instruction entries.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO with flush and occupancy count; the head is read straight
// from storage, so a pushed word becomes visible the cycle after the push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign head = mem[rd_ptr];

  // The owner guarantees no push into a full FIFO without a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, tags
// responses with their PC and buffers them for the core; redirects drop stale data.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halted,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  state_t        state;
  logic [31:0]   pc;
  logic [OCW-1:0] outstanding, drop_cnt;
  logic [FCW-1:0] fifo_count;
  logic [31:0]   tag_pc, in_use;
  fetch_entry_t  head, push_entry;
  logic          redir, rsp_ok, rsp_keep, fire, pop;

  assign redir    = (state == RUN) && redirect_valid;
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (drop_cnt == '0) && !redir;

  // Credits: every accepted, non-dropped request must find a free buffer slot.
  assign in_use = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);

  assign imem_req_valid = (state == RUN) && !redirect_valid &&
                          (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                          (in_use < 32'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign inst_valid = (fifo_count != '0) && (state != HALT) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  assign push_entry = '{inst: imem_rsp_data, pc: tag_pc};

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_inst_fifo (
    .clk       (clk),
    .rst       (rst_b),
    .flush     (redir),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Tag queue occupancy doubles as the outstanding-request count.
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .W(32)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst_b),
    .flush     (1'b0),
    .push      (fire),
    .push_data (pc),
    .pop       (rsp_ok),
    .head      (tag_pc),
    .count     (outstanding)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      drop_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (imem_rsp_valid && (outstanding == '0)) fetch_err <= 1'b1;

      // Everything still in flight after this cycle's response is stale.
      if (redir)                          drop_cnt <= outstanding - OCW'(rsp_ok);
      else if (rsp_ok && drop_cnt != '0)  drop_cnt <= drop_cnt - OCW'(1);

      if (redir)     pc <= {redirect_target[31:2], 2'b00};
      else if (fire) pc <= pc + 32'(WORD_BYTES);

      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halted) state <= HALT;
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an in-order variable-latency
// memory model plus an expected instruction stream derived from PC sequencing.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int FD = 2;
  localparam int MO = 2;

  logic        clk, rst_b;
  logic        redirect_valid, halted;
  logic [31:0] redirect_target;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        inst_valid, inst_ready, fetch_err;
  logic [31:0] inst, inst_pc;

  logic        mem_rsp_v, spur_v;
  logic [31:0] mem_rsp_d;
  assign imem_rsp_valid = mem_rsp_v | spur_v;
  assign imem_rsp_data  = spur_v ? 32'hDEAD_BEEF : mem_rsp_d;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_b(rst_b),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h3C5A_96E1;
  endfunction

  // Memory model and expected-stream generator
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  req_exp;
  int lat_min = 1, lat_max = 1, ready_pct = 100;

  initial begin
    mem_rsp_v = 1'b0; mem_rsp_d = '0; imem_req_ready = 1'b0; req_exp = RPC;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        pend.delete(); exp_q.delete(); req_exp = RPC;
      end else if (redirect_valid) begin
        exp_q.delete(); req_exp = {redirect_target[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, req_exp);
        chk("outstanding_limit", 32'(pend.size() < MO), 32'd1);
        pend.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        exp_q.push_back('{inst: mem_word(req_exp), pc: req_exp});
        req_exp = req_exp + 32'd4;
      end
      @(posedge clk); #1;
      if (mem_rsp_v && pend.size() > 0) void'(pend.pop_front());
      mem_rsp_v = 1'b0;
      if (!rst_b && pend.size() > 0 && pend[0].due <= cyc + 1) begin
        mem_rsp_v = 1'b1;
        mem_rsp_d = mem_word(pend[0].addr);
      end
      imem_req_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Scoreboard monitor: every consumed instruction must be the next expected one
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst_b && inst_valid && inst_ready) begin
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.inst);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst_b = 1'b1; redirect_valid = 1'b0; halted = 1'b0; spur_v = 1'b0;
    step(2);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    @(posedge clk); #1;
  endtask

  task automatic release_boot;
    rst_b = 1'b0;
    @(negedge clk);
    chk("boot_no_req", 32'(imem_req_valid), 0);
    @(posedge clk); #1;
    spur_v = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pend(input int n, input string nm);
    int k = 0;
    while (pend.size() != n && k < 100) begin @(posedge clk); #2; k++; end
    chk(nm, 32'(pend.size()), 32'(n));
  endtask

  initial begin
    int bad, k;
    redirect_target = '0; inst_ready = 1'b1; spur_v = 1'b0;
    do_reset();
    release_boot();

    // Sequential fetch, latency 1 then 3
    step(40);
    chk("err_after_seq", 32'(fetch_err), 0);
    lat_min = 3; lat_max = 3;
    step(40);

    // Core stalls: buffer fills, requests stop, then drains in order
    lat_min = 1;
    inst_ready = 1'b0;
    step(10);
    @(negedge clk);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_inst_valid", 32'(inst_valid), 1);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    step(20);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    wait_pend(2, "two_in_flight");
    redirect(32'h0040_0103);
    k = 0;
    @(negedge clk);
    while (!inst_valid && k < 50) begin @(negedge clk); k++; end
    chk("first_pc_after_redir", inst_pc, 32'h0040_0100);
    @(posedge clk); #1;
    step(10);

    // Address wrap
    lat_min = 1; lat_max = 2;
    redirect(32'hFFFF_FFF9);
    step(20);

    // Randomized traffic with occasional redirects
    lat_max = 4; ready_pct = 60;
    for (int i = 0; i < 400; i++) begin
      inst_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 3) redirect($urandom);
      else step(1);
    end
    inst_ready = 1'b1; ready_pct = 100;
    step(20);
    chk("err_after_random", 32'(fetch_err), 0);

    // Halt with one request in flight
    lat_min = 4; lat_max = 4;
    wait_pend(1, "one_in_flight");
    halted = 1'b1;
    step(1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req_valid || inst_valid) bad++;
    end
    @(posedge clk); #1;
    chk("halt_quiet_cycles", 32'(bad), 0);
    chk("halt_rsp_absorbed", 32'(pend.size()), 0);
    chk("halt_err", 32'(fetch_err), 0);
    lat_min = 1; lat_max = 3;
    do_reset();
    release_boot();
    step(30);

    // Spurious response with nothing outstanding
    ready_pct = 0;
    do_reset();
    spur_v = 1'b1;
    release_boot();
    step(4);
    @(negedge clk);
    chk("spur_err_set", 32'(fetch_err), 1);
    chk("spur_fifo_empty", 32'(inst_valid), 0);
    @(posedge clk); #1;
    ready_pct = 100;
    step(25);
    chk("spur_err_sticky", 32'(fetch_err), 1);
    do_reset();
    release_boot();
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle MIPS core.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers returned words in a small FIFO and presents them to the core as inst / inst_pc with valid/ready.
- Branch, jump and jr targets arrive from the core as a redirect; stale in-flight fetches are discarded.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_b  in  1  reset, asynchronous and active-high (1 = reset asserted).
redirect_valid  in  1  core requests a fetch-stream change this cycle.
redirect_target  in  32  new PC; bits [1:0] ignored, forced to 0.
halted  in  1  core has executed halt.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request.
imem_req_addr  out  32  word address (byte address, [1:0]=0).
imem_rsp_valid  in  1  response word valid (in request order).
imem_rsp_data  in  32  instruction word.
inst_valid  out  1  inst / inst_pc valid to the core.
inst_ready  in  1  core consumes the instruction.
inst  out  32  instruction word, FIFO head.
inst_pc  out  32  PC of inst.
fetch_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, while rst_b=1):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=BOOT; fetch_err=0.
  - All valid outputs 0; imem_req_addr=RESET_PC; inst=0; inst_pc=0.
- FSM states:
  - BOOT: one cycle with no request, then RUN.
  - RUN: normal fetching.
  - HALT: entered from RUN when halted=1 is sampled; left only by reset.
- Request issue, RUN only. imem_req_valid=1 iff all of:
  - redirect_valid=0;
  - outstanding < MAX_OUTSTANDING;
  - (outstanding - drop_cnt) + fifo_count < FIFO_DEPTH (credit rule; a response always has a free slot).
- imem_req_addr = pc, held stable while valid && !ready. On valid&&ready: pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding += 1. The request's pc is pushed into an internal pc-tag queue.
- Response handling, any state:
  - If drop_cnt>0: discard, drop_cnt -= 1.
  - Otherwise push {imem_rsp_data, tag pc} into the FIFO.
  - Both cases: outstanding -= 1, pop tag.
- Response with outstanding=0: ignored, fetch_err <= 1 (sticky until reset).
- Redirect (RUN, redirect_valid=1):
  - pc <= {target[31:2],2'b00}; no request that cycle; FIFO flushed.
  - drop_cnt <= outstanding after this cycle's response accounting (a response arriving in the redirect cycle is itself discarded).
  - inst_ready is ignored that cycle.
- Output side: inst_valid = FIFO non-empty && state!=HALT && redirect_valid=0. Pop on inst_valid && inst_ready. Push and pop in the same cycle is legal, including when full.
- HALT: no new requests. In-flight responses are still absorbed (buffered or dropped). inst_valid=0.
- Latency: request accepted at cycle N, response at N+k (k>=1), inst_valid earliest at N+k+1 (registered FIFO output). PC of the first fetch = RESET_PC, issued in the cycle after BOOT.
- Simultaneous response, pop and issue in one cycle: counters update by net amount. The credit rule is evaluated on pre-update values.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, RUN, HALT};
  - constant WORD_BYTES=4;
  - typedef fetch_entry_t = struct {inst[31:0], pc[31:0]}.
- One sub-module: fetch_fifo (parameterised depth, flush input, push/pop/count). Used twice: the instruction buffer, and the pc-tag queue with depth MAX_OUTSTANDING.

Test Plan:
- Reset, RESET_PC=32'h0040_0000, memory latency 1, inst_ready=1 -> requests to 0x400000, 0x400004, 0x400008...; inst_pc matches; inst equals memory contents; fetch_err=0.
- Memory latency 3, MAX_OUTSTANDING=2 -> never more than 2 unanswered requests; no FIFO overflow; order preserved.
- inst_ready=0 for 10 cycles -> at most FIFO_DEPTH words buffered, imem_req_valid drops to 0; release returns the words in order with no loss.
- Two requests in flight (0x400008, 0x40000C), redirect_target=32'h0040_0103 -> both stale responses discarded; next request addr 0x400100; first inst_pc after redirect = 0x400100.
- halted=1 with one request in flight -> no further requests; inst_valid=0 thereafter; the response is absorbed; reset restarts from RESET_PC.
- Spurious imem_rsp_valid with nothing outstanding -> fetch_err=1 and stays 1; FIFO unchanged; reset clears it.
